// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: sequencing front-end for an external combinational 32-bit ALU.
// Registers each accepted request onto the ALU inputs, holds them for
// SETTLE_CYCLES, then captures {alu_out, op, tag} into a show-ahead response FIFO.
module alu_req_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,  // 1..15
  parameter int unsigned FIFO_DEPTH    = 4,  // power of two, 2..16
  parameter int unsigned TAG_W         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_in1,
  input  logic [31:0]                   req_in2,
  input  logic [2:0]                    req_op,
  input  logic [TAG_W-1:0]              req_tag,
  output logic [31:0]                   alu_in1,
  output logic [31:0]                   alu_in2,
  output logic [2:0]                    alu_op,
  input  logic [31:0]                   alu_out,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_data,
  output logic [2:0]                    resp_op,
  output logic [TAG_W-1:0]              resp_tag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         settle_q, settle_d;
  logic [31:0]        alu_in1_q, alu_in1_d;
  logic [31:0]        alu_in2_q, alu_in2_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        mem_data [FIFO_DEPTH];
  logic [2:0]         mem_op   [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_nempty;

  // Full is derived from the registered count, so a same-cycle pop never frees
  // a slot for this cycle's push.
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nempty = (count_q != '0);

  // Ready only in IDLE and forced low while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign pop       = fifo_nempty && resp_ready;

  // Next-state and datapath-load logic for the request sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    settle_d  = settle_q;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    alu_op_d  = alu_op_q;
    tag_d     = tag_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_in1_d = req_in1;
          alu_in2_d = req_in2;
          alu_op_d  = req_op;
          tag_d     = req_tag;
          settle_d  = 4'(SETTLE_CYCLES);
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = WRITE;
      end
      WRITE: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and operand registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state elements use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q   <= IDLE;
      settle_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= '0;
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
      alu_op_q  <= alu_op_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Response storage write port.
  // NOTE: the storage array has no reset; entries are only visible through the
  // count-gated outputs, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= alu_out;
      mem_op[wr_ptr_q]   <= alu_op_q;
      mem_tag[wr_ptr_q]  <= tag_q;
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_op     = alu_op_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign resp_valid = fifo_nempty;
  assign resp_data  = fifo_nempty ? mem_data[rd_ptr_q] : '0;
  assign resp_op    = fifo_nempty ? mem_op[rd_ptr_q]   : '0;
  assign resp_tag   = fifo_nempty ? mem_tag[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Self-checking bench for alu_req_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_alu_req_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;

  // Instance with SETTLE_CYCLES=1
  logic        req_valid, req_ready;
  logic [31:0] req_in1, req_in2;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [2:0]  resp_op;
  logic [3:0]  resp_tag;
  logic        busy;
  logic [2:0]  fifo_count;

  // Instance with SETTLE_CYCLES=3
  logic        req3_valid, req3_ready;
  logic [31:0] req3_in1, req3_in2;
  logic [2:0]  req3_op;
  logic [3:0]  req3_tag;
  logic [31:0] alu3_in1, alu3_in2, alu3_out;
  logic [2:0]  alu3_op;
  logic        resp3_valid, resp3_ready;
  logic [31:0] resp3_data;
  logic [2:0]  resp3_op;
  logic [3:0]  resp3_tag;
  logic        busy3;
  logic [2:0]  fifo_count3;

  // Bench ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass in1
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_in1, alu_in2, alu_op);
  assign alu3_out = alu_f(alu3_in1, alu3_in2, alu3_op);

  alu_req_ctrl #(.SETTLE_CYCLES(1), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op), .req_tag(req_tag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_op(resp_op), .resp_tag(resp_tag),
    .busy(busy), .fifo_count(fifo_count)
  );

  alu_req_ctrl #(.SETTLE_CYCLES(3), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req3_valid), .req_ready(req3_ready),
    .req_in1(req3_in1), .req_in2(req3_in2), .req_op(req3_op), .req_tag(req3_tag),
    .alu_in1(alu3_in1), .alu_in2(alu3_in2), .alu_op(alu3_op), .alu_out(alu3_out),
    .resp_valid(resp3_valid), .resp_ready(resp3_ready),
    .resp_data(resp3_data), .resp_op(resp3_op), .resp_tag(resp3_tag),
    .busy(busy3), .fifo_count(fifo_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  op;
    logic [3:0]  tag;
  } resp_t;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] exp_data;
  } vec_t;

  resp_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    pops     = 0;
  bit    acc      = 1'b0;
  bit    rand_rr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, advance past the rising edge.
  task automatic tick();
    bit    acc_pending;
    resp_t e;
    @(negedge clk);
    if (resp_valid && resp_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_op", 32'(resp_op), 32'(e.op));
        check("resp_tag", 32'(resp_tag), 32'(e.tag));
      end
    end
    acc_pending = req_valid && req_ready;
    if (acc_pending) exp_q.push_back('{alu_f(req_in1, req_in2, req_op), req_op, req_tag});
    check("fifo_count_bound", 32'(fifo_count <= 3'(DEPTH)), 32'd1);
    @(posedge clk);
    acc = acc_pending;
    cyc++;
    #1;
    if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int n = 0;
    req_in1 = a; req_in2 = b; req_op = op; req_tag = tag;
    req_valid = 1'b1;
    acc = 1'b0;
    while (!acc && n < 50) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd1, 32'd0);
    check("req_ready_after_accept", 32'(req_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) check("drain_timeout", 32'd1, 32'd0);
    resp_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int c1, c2;
    logic [31:0] last_in1;

    vecs[0] = '{32'd154345,     32'd23167,      3'd0, 4'd3, 32'd177512};
    vecs[1] = '{32'd154345,     32'd23167,      3'd1, 4'd4, 32'd131178};
    vecs[2] = '{32'd567,        32'd2,          3'd0, 4'd5, 32'd569};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          3'd0, 4'd6, 32'd0};
    vecs[4] = '{32'd0,          32'd1,          3'd1, 4'd7, 32'hFFFF_FFFF};
    vecs[5] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  3'd2, 4'd8, 32'hF000_F000};
    vecs[6] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  3'd3, 4'd9, 32'hFFF0_FFF0};
    vecs[7] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  3'd4, 4'd10, 32'h0FF0_0FF0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_in1 = '0; req_in2 = '0; req_op = '0; req_tag = '0;
    resp_ready = 1'b0;
    req3_valid = 1'b0; req3_in1 = '0; req3_in2 = '0; req3_op = '0; req3_tag = '0;
    resp3_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst3_req_ready", 32'(req3_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Directed vector table: latency and head contents for each op
    foreach (vecs[i]) begin
      resp_ready = 1'b0;
      send(vecs[i].in1, vecs[i].in2, vecs[i].op, vecs[i].tag);
      lat = 0;
      while (!resp_valid && lat < 10) begin
        tick();
        lat++;
      end
      check("vec_latency", 32'(lat), 32'd2);
      check("vec_data", resp_data, vecs[i].exp_data);
      check("vec_op", 32'(resp_op), 32'(vecs[i].op));
      check("vec_tag", 32'(resp_tag), 32'(vecs[i].tag));
      check("vec_count", 32'(fifo_count), 32'd1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("vec_empty_data", resp_data, 32'd0);
      check("vec_empty_tag", 32'(resp_tag), 32'd0);
    end

    // Back-to-back acceptance spacing is SETTLE_CYCLES+2
    resp_ready = 1'b1;
    send(32'd154345, 32'd23167, 3'd1, 4'd1);
    c1 = cyc;
    send(32'd567, 32'd2, 3'd0, 4'd2);
    c2 = cyc;
    check("b2b_spacing", 32'(c2 - c1), 32'd3);
    drain();

    // SETTLE_CYCLES=3 on the second instance
    check("s3_ready", 32'(req3_ready), 32'd1);
    req3_in1 = 32'h1234_5678; req3_in2 = 32'h1111_1111; req3_op = 3'd0; req3_tag = 4'd9;
    req3_valid = 1'b1;
    tick();
    req3_valid = 1'b0;
    check("s3_busy", 32'(busy3), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("s3_alu_in1_hold", alu3_in1, 32'h1234_5678);
      check("s3_alu_in2_hold", alu3_in2, 32'h1111_1111);
      check("s3_not_yet", 32'(resp3_valid), 32'd0);
    end
    tick();
    check("s3_resp_valid", 32'(resp3_valid), 32'd1);
    check("s3_resp_data", resp3_data, 32'h2345_6789);
    check("s3_resp_op", 32'(resp3_op), 32'd0);
    check("s3_resp_tag", 32'(resp3_tag), 32'd9);
    check("s3_count", 32'(fifo_count3), 32'd1);
    check("s3_idle", 32'(busy3), 32'd0);

    // FIFO full stall
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      last_in1 = 32'(100 * i + 7);
      send(last_in1, 32'(i), 3'(i % 2), 4'(i));
    end
    repeat (4) tick();
    check("stall_count", 32'(fifo_count), 32'd4);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_alu_in1", alu_in1, last_in1);
    check("stall_head_tag", 32'(resp_tag), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("stall_pop_no_bypass", 32'(fifo_count), 32'd3);
    check("stall_still_busy", 32'(busy), 32'd1);
    tick();
    check("stall_push_count", 32'(fifo_count), 32'd4);
    check("stall_push_idle", 32'(busy), 32'd0);
    drain();

    // Pointer wrap with intermittent consumer, then longer random traffic
    rand_rr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, 3'($urandom_range(0, 7)), 4'(i % 16));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    // Asynchronous reset mid-DRIVE with two queued entries
    resp_ready = 1'b0;
    send(32'd11, 32'd22, 3'd0, 4'd1);
    wait_idle();
    send(32'd33, 32'd44, 3'd0, 4'd2);
    wait_idle();
    send(32'd55, 32'd66, 3'd0, 4'd3);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_in1", alu_in1, 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    pops = 0;
    send(32'd1000, 32'd1, 3'd1, 4'd12);
    drain();
    check("post_rst_pops", 32'(pops), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
